// File: rtl/operand2_shifter_if.sv
// Bundle between the operand source, the operand2 shifter and the ALU.
// The master side drives operands and consumes results; the slave is the shifter.
interface operand2_shifter_if #(
   parameter int DATA_W = 32,
   parameter int AMT_W  = 8
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic              imm_mode;
   logic [DATA_W-1:0] rm_value;
   logic [2:0]        shift_type;
   logic [AMT_W-1:0]  shift_amt;
   logic [7:0]        imm8;
   logic [3:0]        rot4;
   logic              carry_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] src2;
   logic              src2shift_carry;
   logic              was_shifted;

   modport master (
      output flush, in_valid, imm_mode, rm_value, shift_type, shift_amt,
             imm8, rot4, carry_in, out_ready,
      input  in_ready, out_valid, src2, src2shift_carry, was_shifted
   );

   modport slave (
      input  flush, in_valid, imm_mode, rm_value, shift_type, shift_amt,
             imm8, rot4, carry_in, out_ready,
      output in_ready, out_valid, src2, src2shift_carry, was_shifted
   );
endinterface

// File: rtl/operand2_shifter.sv
// Second-operand barrel shifter ahead of the ALU: one registered stage with
// valid/ready handshake and flush. Only DATA_W=32 is supported.
module operand2_shifter #(
   parameter int DATA_W = 32,
   parameter int AMT_W  = 8
) (
   input  logic               CLOCK_50,
   input  logic               RESET,
   operand2_shifter_if.slave  bus
);

   localparam logic [2:0] ST_LSL = 3'b000;
   localparam logic [2:0] ST_LSR = 3'b001;
   localparam logic [2:0] ST_ASR = 3'b010;
   localparam logic [2:0] ST_ROR = 3'b011;
   localparam logic [2:0] ST_RRX = 3'b100;

   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
      return (x >> r) | (x << (6'd32 - {1'b0, r}));
   endfunction

   logic [DATA_W-1:0] rm;
   logic [AMT_W-1:0]  n;
   logic [4:0]        n5;
   logic              n_zero, n_lt32, n_eq32;
   logic [DATA_W:0]   lsl_t, lsr_t;
   logic signed [DATA_W:0] asr_t;
   logic [DATA_W-1:0] ror_t;

   assign rm     = bus.rm_value;
   assign n      = bus.shift_amt;
   assign n5     = n[4:0];
   assign n_zero = (n == '0);
   assign n_lt32 = (n[AMT_W-1:5] == '0);
   assign n_eq32 = (n == AMT_W'(32));

   // Extra bit on each side catches the last bit shifted out (the carry).
   assign lsl_t = {1'b0, rm} << n5;
   assign lsr_t = {rm, 1'b0} >> n5;
   assign asr_t = $signed({rm, 1'b0}) >>> n5;
   assign ror_t = ror32(rm, n5);

   logic [DATA_W-1:0] sh_val;
   logic              sh_cy, sh_flag;

   always_comb begin
      sh_val  = rm;
      sh_cy   = bus.carry_in;
      sh_flag = 1'b0;
      if (bus.imm_mode) begin
         sh_val = ror32({24'b0, bus.imm8}, {bus.rot4, 1'b0});
         if (bus.rot4 != '0) begin
            sh_cy   = sh_val[DATA_W-1];
            sh_flag = 1'b1;
         end
      end else begin
         case (bus.shift_type)
            ST_RRX: begin
               sh_val  = {bus.carry_in, rm[DATA_W-1:1]};
               sh_cy   = rm[0];
               sh_flag = 1'b1;
            end
            ST_LSL: if (!n_zero) begin
               sh_flag = 1'b1;
               if (n_lt32) begin
                  sh_val = lsl_t[DATA_W-1:0];
                  sh_cy  = lsl_t[DATA_W];
               end else begin
                  sh_val = '0;
                  sh_cy  = n_eq32 ? rm[0] : 1'b0;
               end
            end
            ST_LSR: if (!n_zero) begin
               sh_flag = 1'b1;
               if (n_lt32) begin
                  sh_val = lsr_t[DATA_W:1];
                  sh_cy  = lsr_t[0];
               end else begin
                  sh_val = '0;
                  sh_cy  = n_eq32 ? rm[DATA_W-1] : 1'b0;
               end
            end
            ST_ASR: if (!n_zero) begin
               sh_flag = 1'b1;
               if (n_lt32) begin
                  sh_val = asr_t[DATA_W:1];
                  sh_cy  = asr_t[0];
               end else begin
                  sh_val = {DATA_W{rm[DATA_W-1]}};
                  sh_cy  = rm[DATA_W-1];
               end
            end
            ST_ROR: if (!n_zero) begin
               // n a multiple of 32 leaves rm intact; carry is still its MSB.
               sh_flag = 1'b1;
               sh_val  = ror_t;
               sh_cy   = ror_t[DATA_W-1];
            end
            default: ;
         endcase
      end
   end

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] src2_q, src2_d;
   logic              carry_q, carry_d;
   logic              shifted_q, shifted_d;
   logic              in_ready, accept;

   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      src2_d      = src2_q;
      carry_d     = carry_q;
      shifted_d   = shifted_q;
      if (accept)
         out_valid_d = 1'b1;
      else if (bus.out_ready)
         out_valid_d = 1'b0;
      // Flush wins over a same-cycle accept; the dropped bundle never loads.
      if (bus.flush)
         out_valid_d = 1'b0;
      if (accept && !bus.flush) begin
         src2_d    = sh_val;
         carry_d   = sh_cy;
         shifted_d = sh_flag;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         out_valid_q <= 1'b0;
         src2_q      <= '0;
         carry_q     <= 1'b0;
         shifted_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         src2_q      <= src2_d;
         carry_q     <= carry_d;
         shifted_q   <= shifted_d;
      end
   end

   assign bus.in_ready        = in_ready;
   assign bus.out_valid       = out_valid_q;
   assign bus.src2            = src2_q;
   assign bus.src2shift_carry = carry_q;
   assign bus.was_shifted     = shifted_q;

endmodule

// File: tb/tb_operand2_shifter.sv
// Directed table-driven bench for operand2_shifter plus hand-written
// sequences for reset, backpressure and flush.
module tb_operand2_shifter;

   logic CLOCK_50 = 1'b0;
   logic RESET;

   operand2_shifter_if bus ();

   operand2_shifter dut (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .bus      (bus.slave)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic        imm_mode;
      logic [31:0] rm;
      logic [2:0]  st;
      logic [7:0]  amt;
      logic [7:0]  imm8;
      logic [3:0]  rot4;
      logic        cin;
      logic [31:0] exp_src2;
      logic        exp_c;
      logic        exp_sh;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   logic        collect = 1'b0;
   logic [31:0] got_q[$];

   always @(posedge CLOCK_50)
      if (collect && !RESET && bus.out_valid && bus.out_ready)
         got_q.push_back(bus.src2);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive_reg(input logic [31:0] rm, input logic [2:0] st, input logic [7:0] amt,
                            input logic cin);
      bus.imm_mode   = 1'b0;
      bus.rm_value   = rm;
      bus.shift_type = st;
      bus.shift_amt  = amt;
      bus.imm8       = 8'h00;
      bus.rot4       = 4'h0;
      bus.carry_in   = cin;
   endtask

   vec_t vecs[19];

   initial begin
      //            imm  rm            st     amt    imm8   rot4 cin exp_src2      c     sh
      vecs[0]  = '{1'b0, 32'h8000_0001, 3'd0, 8'd1,  8'h00, 4'd0, 1'b0, 32'h0000_0002, 1'b1, 1'b1};
      vecs[1]  = '{1'b0, 32'h8000_0001, 3'd1, 8'd32, 8'h00, 4'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[2]  = '{1'b0, 32'h8000_0001, 3'd2, 8'd40, 8'h00, 4'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 32'h8000_0001, 3'd3, 8'd33, 8'h00, 4'd0, 1'b0, 32'hC000_0000, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 32'h8000_0001, 3'd0, 8'd0,  8'h00, 4'd0, 1'b1, 32'h8000_0001, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0003, 3'd4, 8'd0,  8'h00, 4'd0, 1'b1, 32'h8000_0001, 1'b1, 1'b1};
      vecs[6]  = '{1'b1, 32'h1234_5678, 3'd3, 8'd7,  8'hFF, 4'd4, 1'b0, 32'hFF00_0000, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 32'h0000_0000, 3'd0, 8'd0,  8'h3C, 4'd0, 1'b1, 32'h0000_003C, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 32'h8000_0001, 3'd0, 8'd32, 8'h00, 4'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 32'h8000_0001, 3'd0, 8'd33, 8'h00, 4'd0, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 32'hF000_0008, 3'd1, 8'd4,  8'h00, 4'd0, 1'b0, 32'h0F00_0000, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 32'h8000_0010, 3'd2, 8'd4,  8'h00, 4'd0, 1'b1, 32'hF800_0001, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 32'h8000_0001, 3'd3, 8'd32, 8'h00, 4'd0, 1'b0, 32'h8000_0001, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 32'h0000_1234, 3'd5, 8'd3,  8'h00, 4'd0, 1'b0, 32'h0000_1234, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_0003, 3'd0, 8'd31, 8'h00, 4'd0, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
      vecs[15] = '{1'b1, 32'h0000_0000, 3'd0, 8'd0,  8'h03, 4'd1, 1'b0, 32'hC000_0000, 1'b1, 1'b1};
      vecs[16] = '{1'b0, 32'h8000_0000, 3'd2, 8'd0,  8'h00, 4'd0, 1'b0, 32'h8000_0000, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 32'hFFFF_FFFF, 3'd1, 8'd33, 8'h00, 4'd0, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
      vecs[18] = '{1'b1, 32'h0000_0000, 3'd0, 8'd0,  8'h80, 4'd15, 1'b1, 32'h0000_0200, 1'b0, 1'b1};

      RESET         = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive_reg(32'h0, 3'd0, 8'd0, 1'b0);

      #12;
      chk("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("reset src2", bus.src2, 32'd0);
      chk("reset carry", {31'b0, bus.src2shift_carry}, 32'd0);
      chk("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(negedge CLOCK_50) RESET = 1'b0;

      // Table: back-to-back, one result per cycle with out_ready held high
      for (int i = 0; i < 19; i++) begin
         @(negedge CLOCK_50);
         bus.imm_mode   = vecs[i].imm_mode;
         bus.rm_value   = vecs[i].rm;
         bus.shift_type = vecs[i].st;
         bus.shift_amt  = vecs[i].amt;
         bus.imm8       = vecs[i].imm8;
         bus.rot4       = vecs[i].rot4;
         bus.carry_in   = vecs[i].cin;
         bus.in_valid   = 1'b1;
         bus.out_ready  = 1'b1;
         @(posedge CLOCK_50); #1;
         chk($sformatf("vec%0d out_valid", i), {31'b0, bus.out_valid}, 32'd1);
         chk($sformatf("vec%0d src2", i), bus.src2, vecs[i].exp_src2);
         chk($sformatf("vec%0d carry", i), {31'b0, bus.src2shift_carry}, {31'b0, vecs[i].exp_c});
         chk($sformatf("vec%0d was_shifted", i), {31'b0, bus.was_shifted}, {31'b0, vecs[i].exp_sh});
      end
      @(negedge CLOCK_50) bus.in_valid = 1'b0;
      @(posedge CLOCK_50); #1;
      chk("drain out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("drain src2 held", bus.src2, 32'h0000_0200);

      // Backpressure: A, B, C with a two-cycle stall after A
      got_q.delete();
      collect = 1'b1;
      @(negedge CLOCK_50);
      bus.out_ready = 1'b0;
      drive_reg(32'h0000_0001, 3'd0, 8'd1, 1'b0);
      bus.in_valid = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      drive_reg(32'h0000_0002, 3'd0, 8'd1, 1'b0);
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("stall%0d out_valid", s), {31'b0, bus.out_valid}, 32'd1);
         chk($sformatf("stall%0d src2", s), bus.src2, 32'h0000_0002);
         chk($sformatf("stall%0d in_ready", s), {31'b0, bus.in_ready}, 32'd0);
         @(posedge CLOCK_50);
         @(negedge CLOCK_50);
      end
      bus.out_ready = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      drive_reg(32'h0000_0004, 3'd0, 8'd1, 1'b0);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      bus.in_valid = 1'b0;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("bp drained out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("bp count", got_q.size(), 32'd3);
      if (got_q.size() == 3) begin
         chk("bp item0", got_q[0], 32'h0000_0002);
         chk("bp item1", got_q[1], 32'h0000_0004);
         chk("bp item2", got_q[2], 32'h0000_0008);
      end

      // Flush with a simultaneous accept drops the new bundle
      got_q.delete();
      bus.out_ready = 1'b0;
      drive_reg(32'h0000_0001, 3'd0, 8'd1, 1'b0);
      bus.in_valid = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      drive_reg(32'h0000_0008, 3'd0, 8'd1, 1'b0);
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk("flush in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(posedge CLOCK_50); #1;
      chk("flush out_valid", {31'b0, bus.out_valid}, 32'd0);
      @(negedge CLOCK_50);
      bus.flush = 1'b0;
      drive_reg(32'h0000_0010, 3'd0, 8'd1, 1'b0);
      @(posedge CLOCK_50); #1;
      chk("post-flush out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("post-flush src2", bus.src2, 32'h0000_0020);
      @(negedge CLOCK_50) bus.in_valid = 1'b0;
      @(posedge CLOCK_50); #1;
      chk("post-flush drained", {31'b0, bus.out_valid}, 32'd0);
      chk("flush count", got_q.size(), 32'd2);
      if (got_q.size() == 2) begin
         chk("flush item0", got_q[0], 32'h0000_0002);
         chk("flush item1", got_q[1], 32'h0000_0020);
      end
      collect = 1'b0;

      // Asynchronous reset while a result is held
      @(negedge CLOCK_50);
      bus.out_ready = 1'b0;
      drive_reg(32'h8000_0001, 3'd3, 8'd1, 1'b0);
      bus.in_valid = 1'b1;
      @(posedge CLOCK_50); #1;
      chk("pre-reset out_valid", {31'b0, bus.out_valid}, 32'd1);
      @(negedge CLOCK_50);
      bus.in_valid = 1'b0;
      #2 RESET = 1'b1;
      #1;
      chk("async reset out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("async reset src2", bus.src2, 32'd0);
      chk("async reset carry", {31'b0, bus.src2shift_carry}, 32'd0);
      chk("async reset was_shifted", {31'b0, bus.was_shifted}, 32'd0);
      @(negedge CLOCK_50) RESET = 1'b0;
      #1;
      chk("post-reset in_ready", {31'b0, bus.in_ready}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/operand2_shifter.md
Name: operand2_shifter

Overview:
- Pipelined second-operand stage directly upstream of the ALU.
- Takes the raw second operand, either a register value or an 8-bit immediate with a rotate field, and applies the barrel shift or rotate.
- Registers three outputs for the ALU's second-operand inputs: the shifted value, the shifter carry-out, and a was-shifted indication.
- Uses a valid/ready handshake with exactly one register stage. A flush input discards in-flight work on branches.

Parameters:
- DATA_W, 32, operand width; only 32 is supported.
- AMT_W, 8, width of the register-specified shift amount.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; drops the registered result.
- in_valid  in  1  input operand bundle is valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- imm_mode  in  1  1 = rotated immediate; 0 = shifted register.
- rm_value  in  32  register operand (used when imm_mode=0).
- shift_type  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, others reserved.
- shift_amt  in  8  shift amount, 0..255 (used when imm_mode=0).
- imm8  in  8  immediate byte (used when imm_mode=1).
- rot4  in  4  immediate rotate field; rotate right by 2*rot4.
- carry_in  in  1  current C flag from the flag register.
- out_valid  out  1  registered result is valid.
- out_ready  in  1  ALU consumes the result this cycle.
- src2  out  32  shifted or rotated operand.
- src2shift_carry  out  1  shifter carry-out.
- was_shifted  out  1  1 when a shift actually occurred and src2shift_carry must override C.

Behaviour:
- Reset: on RESET high, immediately and asynchronously clear out_valid, src2, src2shift_carry and was_shifted to 0. Reset mid-transfer loses the bundle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An accept happens when in_valid && in_ready; the result is registered at that edge.
  - Latency is 1 cycle; throughput is 1 per cycle when out_ready is held high.
  - When out_valid && !out_ready, the outputs hold stable and in_ready is 0.
  - When the stage accepts and is not also consuming, out_valid goes to 1.
  - When the ALU consumes with no new accept, out_valid goes to 0; the data outputs keep their last value.
- Flush: at the edge, flush forces out_valid to 0 and overrides any simultaneous accept (the input is dropped). in_ready is unaffected by flush.
- Pass-through (applies to LSL, LSR, ASR, ROR and any reserved shift_type): if n = shift_amt is 0, or shift_type is reserved, then src2=rm_value, src2shift_carry=carry_in, was_shifted=0.
- Register mode, n>0 (was_shifted=1 in all of these cases):
  - LSL: n 1..31 gives rm<<n with carry rm[32-n]. n=32 gives 0 with carry rm[0]. n>32 gives 0 with carry 0.
  - LSR: n 1..31 gives rm>>n with carry rm[n-1]. n=32 gives 0 with carry rm[31]. n>32 gives 0 with carry 0.
  - ASR: n 1..31 gives the arithmetic shift with carry rm[n-1]. n>=32 gives all bits equal to rm[31], with carry rm[31].
  - ROR: let r = n mod 32. If r≠0, the result is rotate-right by r with carry = result[31]. If r=0 (n=32, 64, …), the result is rm unchanged with carry rm[31].
- RRX (shift_amt ignored): src2={carry_in, rm[31:1]}, carry rm[0], was_shifted=1.
- Immediate mode (shift_type and shift_amt ignored): src2 = zero-extended imm8 rotated right by 2*rot4.
  - rot4=0: carry_in passes through and was_shifted=0.
  - rot4≠0: carry = src2[31] and was_shifted=1.
- Datapath is combinational from inputs to the output register only; there are no combinational paths from inputs to outputs other than in_ready.

Test Plan:
- Reset/idle: assert RESET mid-stream while out_valid=1 → all outputs 0 immediately; in_ready=1 after release.
- Register shifts, out_ready=1, carry_in=0, rm=0x8000_0001; each result appears 1 cycle after accept:
  - LSL 1 → src2=0x0000_0002, carry 1, was_shifted 1.
  - LSR 32 → 0x0000_0000, carry 1.
  - ASR 40 → 0xFFFF_FFFF, carry 1.
  - ROR 33 → 0xC000_0000, carry 1.
  - LSL 0 with carry_in=1 → 0x8000_0001, carry 1, was_shifted 0.
- RRX, carry_in=1, rm=0x0000_0003 → src2=0x8000_0001, carry 1, was_shifted 1.
- Immediate mode:
  - imm8=0xFF, rot4=4 → src2=0xFF00_0000, carry 1, was_shifted 1.
  - imm8=0x3C, rot4=0, carry_in=1 → 0x0000_003C, carry 1, was_shifted 0.
- Backpressure: 3 back-to-back bundles with out_ready=0 for 2 cycles → first result held stable, in_ready=0 while stalled; after out_ready=1, all three delivered in order, none lost or duplicated.
- Flush: flush=1 together with in_valid=1 while out_valid=1 → next cycle out_valid=0 and the new bundle is not delivered; the following accept works normally.
